multicycle_controller: RTL

Main control FSM for the multicycle MIPS datapath. Each instruction runs through fetch, decode, execute, memory and writeback states. The block drives the datapath mux selects and write enables, and issues the 2-bit `alu_op` consumed by the ALU control decoder. Memory accesses use a request/ready handshake so the core can stall on slow memory.

---
 rtl/multicycle_controller.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM for the multicycle MIPS datapath with memory stall handshake
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal_op,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t r_state;
    logic   w_legal;
    logic   w_mem_req;
    logic   w_mem_write;
    logic   w_ir_write;
    logic   w_reg_write;
    logic   w_pc_write;
    logic   w_branch;
    logic   w_illegal;

    assign w_legal = op inside {OP_LW, OP_SW, OP_RTYP, OP_BEQ, OP_ADDI, OP_J};

    // State register: reset wins over every transition, including a pending memory wait
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            case (r_state)
                FETCH:   r_state <= mem_ready ? DECODE : FETCH;
                DECODE:  begin
                    case (op)
                        OP_LW, OP_SW: r_state <= MEMADR;
                        OP_RTYP:      r_state <= RTYPEEX;
                        OP_BEQ:       r_state <= BEQEX;
                        OP_ADDI:      r_state <= ADDIEX;
                        OP_J:         r_state <= JEX;
                        default:      r_state <= FETCH;
                    endcase
                end
                MEMADR:  r_state <= (op == OP_SW) ? MEMWR : MEMRD;
                MEMRD:   r_state <= mem_ready ? MEMWB : MEMRD;
                MEMWR:   r_state <= mem_ready ? FETCH : MEMWR;
                RTYPEEX: r_state <= RTYPEWB;
                ADDIEX:  r_state <= ADDIWB;
                default: r_state <= FETCH;
            endcase
        end
    end

    // Moore decode of the datapath controls; FETCH load strobes follow mem_ready
    always_comb begin
        w_mem_req   = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_pc_write  = 1'b0;
        w_branch    = 1'b0;
        w_illegal   = 1'b0;
        i_or_d      = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_op      = 2'b00;
        pc_src      = 2'b00;
        case (r_state)
            FETCH: begin
                w_mem_req  = 1'b1;
                alu_src_b  = 2'b01;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                w_illegal = ~w_legal;
            end
            MEMADR, ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                w_mem_req = 1'b1;
                i_or_d    = 1'b1;
            end
            MEMWB: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 1'b1;
            end
            MEMWR: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                i_or_d      = 1'b1;
            end
            RTYPEEX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            RTYPEWB: begin
                w_reg_write = 1'b1;
                reg_dst     = 1'b1;
            end
            BEQEX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                w_branch  = 1'b1;
            end
            ADDIWB: w_reg_write = 1'b1;
            JEX: begin
                pc_src     = 2'b10;
                w_pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_req    = w_mem_req & ~reset;
    assign mem_write  = w_mem_write & ~reset;
    assign ir_write   = w_ir_write & ~reset;
    assign reg_write  = w_reg_write & ~reset;
    assign illegal_op = w_illegal & ~reset;
    assign pc_en      = (w_pc_write | (w_branch & zero)) & ~reset;
    assign state      = r_state;
endmodule
